ff_reg_arbiter: RTL and testbench
=================================

// Module: ff_reg_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one WIDTH-bit D-flip-flop holding register among NREQ requesters.
//  A requester raises req, gets a one-hot grant, and its data word is loaded into the shared register.
//  The grant is held for up to HOLD_CYCLES, then ownership passes on in rotation.
//  Sits between requesting blocks and the flip-flop storage so that only one writer owns q at a time.
// PARAMETERS
//  NREQ        4   number of requesters (>=2)
//  WIDTH       8   width of the shared register / each data word
//  HOLD_CYCLES 4   max BUSY cycles per grant (>=1)
// PORTS
//  clk    in   1            clock; all state updates on posedge
//  rst_n  in   1            asynchronous active-low reset
//  req    in   NREQ         request per requester; hold high until done
//  wdata  in   NREQ*WIDTH   packed data; requester i at [i*WIDTH +: WIDTH]
//  gnt    out  NREQ         registered one-hot grant
//  owner  out  clog2(NREQ)  index of current/last grantee
//  q      out  WIDTH        shared register contents
//  q_vld  out  1            q holds the current owner's word
//  busy   out  1            high in every state except IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, gnt=0, owner=0, q=0, q_vld=0, busy=0, ptr=0, cnt=0.
//  FSM IDLE -> LOAD -> BUSY -> RELEASE -> IDLE.
//  IDLE: if |req, winner = first set req at or after ptr (wrapping NREQ-1 -> 0).
//   gnt<=onehot(winner), owner<=winner, busy<=1, ->LOAD. Otherwise stay.
//  LOAD (1 cycle): q<=wdata[owner], q_vld<=1, cnt<=0, ->BUSY. Always taken, even if req[owner] dropped.
//  BUSY: cnt<=cnt+1.
//   If cnt==HOLD_CYCLES-1 or !req[owner]: gnt<=0, q_vld<=0, ->RELEASE.
//   cnt never exceeds HOLD_CYCLES-1.
//  RELEASE (1 cycle): ptr<=(owner==NREQ-1)?0:owner+1, busy<=0, ->IDLE.
//  Latency: req seen at edge k -> gnt high after k; q/q_vld valid after k+1.
//   Next grant after a release is no earlier than 2 edges after gnt falls.
//  q retains its last value after release. Only LOAD writes q; owner stays stable until the next grant.
//  Requests that change in LOAD, BUSY or RELEASE do not alter the current grant.
//   A new req is only arbitrated in IDLE.
//  A single requester that keeps req high is re-granted every HOLD_CYCLES+3 cycles.
//  At most one gnt bit is ever set; gnt=0 in IDLE and RELEASE.
//  Reset asserted mid-operation clears everything immediately; no partial load survives.
// CONFIGURATION
//  FIXED_PRIO_EN defined: winner = lowest-index set req; ptr unused (held 0).
//  FIXED_PRIO_EN undefined (default): round-robin as above.
//  Ports, FSM and timing are identical in both cases.
// TESTING (NREQ=4, WIDTH=8, HOLD_CYCLES=4)
//  Reset: rst_n=0 with req=4'hF -> gnt=0, q=0, q_vld=0, busy=0.
//   Release reset -> gnt=4'b0001 one edge later.
//  Single req[2] held, wdata[2]=8'hA5:
//   -> gnt=4'b0100 for 5 cycles (LOAD+4 BUSY), q=8'hA5, q_vld=1 for 4 cycles, owner=2, then re-grant.
//  req=4'hF held, RR: grant order 0,1,2,3,0.
//   FIXED_PRIO_EN: always 0.
//  Early drop: req[1] falls on 2nd BUSY cycle -> gnt=0 next edge, q_vld=0; q stays at req1's word.
//  rst_n pulsed low during BUSY -> outputs zero asynchronously (same cycle); arbitration restarts with ptr=0.
//  Wrap: owner=3 released with req=4'b1001 -> next grant 4'b0001 (RR).

Source files
------------

// File: rtl/ff_reg_arbiter.sv
// Round-robin arbiter that hands one shared WIDTH-bit holding register to one of NREQ requesters at a time.
// Define FIXED_PRIO_EN to select lowest-index-wins priority instead of round-robin.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no owner; arbitrate among raised requests
// LOAD    | grant issued; capture owner's word into q
// BUSY    | owner holds q until its request drops or the hold time ends
// RELEASE | grant withdrawn; advance rotation pointer, then go idle
module ff_reg_arbiter #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic [WIDTH-1:0]         q,
    output logic                     q_vld,
    output logic                     busy
);

    localparam int OW = $clog2(NREQ);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [OW-1:0] OWNER_LAST = OW'(NREQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_BUSY,
        S_RELEASE
    } state_t;

    state_t          state;
    logic [OW-1:0]   ptr;
    logic [CW-1:0]   cnt;
    logic [OW-1:0]   winner;
    logic            found;
    int              idx;

    // With fixed priority ptr is held at zero, so the same search yields lowest-index-wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx]) begin
                winner = OW'(idx);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            gnt   <= '0;
            owner <= '0;
            q     <= '0;
            q_vld <= 1'b0;
            busy  <= 1'b0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        gnt   <= NREQ'(1) << winner;
                        owner <= winner;
                        busy  <= 1'b1;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    q     <= wdata[int'(owner)*WIDTH +: WIDTH];
                    q_vld <= 1'b1;
                    cnt   <= '0;
                    state <= S_BUSY;
                end
                S_BUSY: begin
                    if (cnt == CNT_LAST || !req[owner]) begin
                        gnt   <= '0;
                        q_vld <= 1'b0;
                        state <= S_RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RELEASE: begin
`ifdef FIXED_PRIO_EN
                    ptr <= '0;
`else
                    ptr <= (owner == OWNER_LAST) ? '0 : owner + 1'b1;
`endif
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ff_reg_arbiter.sv
// Randomized self-checking bench for ff_reg_arbiter against a grant-age reference model.
module tb_ff_reg_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int HOLD  = 4;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NREQ-1:0]        req = '0;
    logic [NREQ*WIDTH-1:0]  wdata = '0;
    logic [NREQ-1:0]        gnt;
    logic [1:0]             owner;
    logic [WIDTH-1:0]       q;
    logic                   q_vld;
    logic                   busy;

    int checks = 0;
    int errors = 0;

    ff_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata),
        .gnt(gnt), .owner(owner), .q(q), .q_vld(q_vld), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: a grant is a transaction aged in clock edges since it was issued.
    logic [3:0] m_gnt;
    logic [1:0] m_owner, m_ptr;
    logic [7:0] m_q;
    bit         m_qv, m_busy, m_active, m_rel;
    int         m_age;

    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] w;
        bit got;
        w = 0;
        got = 0;
        for (int k = 0; k < 4; k++) begin
            int ix;
            ix = (int'(start) + k) % 4;
            if (!got && r[ix]) begin
                w = 2'(ix);
                got = 1;
            end
        end
        return w;
    endfunction

    task automatic model_reset();
        m_gnt = 0; m_owner = 0; m_ptr = 0; m_q = 0;
        m_qv = 0; m_busy = 0; m_active = 0; m_rel = 0; m_age = 0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic [31:0] wd);
        logic [1:0] w;
        if (m_active) begin
            m_age++;
            if (m_age == 1) begin
                m_q  = wd[int'(m_owner)*8 +: 8];
                m_qv = 1;
            end else if (m_age == HOLD + 1 || !r[m_owner]) begin
                m_gnt = 0;
                m_qv = 0;
                m_active = 0;
                m_rel = 1;
            end
        end else if (m_rel) begin
            m_rel = 0;
            m_busy = 0;
`ifdef FIXED_PRIO_EN
            m_ptr = 0;
`else
            m_ptr = 2'((int'(m_owner) + 1) % 4);
`endif
        end else if (|r) begin
            w = pick(r, m_ptr);
            m_gnt = 4'(1 << w);
            m_owner = w;
            m_busy = 1;
            m_active = 1;
            m_age = 0;
        end
    endtask

    task automatic cycle(input logic [3:0] r, input logic [31:0] wd);
        @(negedge clk);
        req = r;
        wdata = wd;
        @(posedge clk);
        model_step(r, wd);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((m_active || m_rel) && n < 30) begin
            cycle(4'h0, $urandom);
            n++;
        end
        checks++;
        if (m_active || m_rel) begin
            errors++;
            $display("FAIL drain: model still busy after %0d cycles, required idle", n);
        end
    endtask

    task automatic test_reset();
        logic [31:0] wd;
        wd = $urandom;
        rst_n = 1'b0;
        req = 4'hF;
        wdata = wd;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({gnt, owner, q, q_vld, busy} !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: got gnt=%b owner=%0d q=%h vld=%b busy=%b, required all zero",
                     gnt, owner, q, q_vld, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_step(4'hF, wd);
        #1;
        checks++;
        if (gnt !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: got gnt=%b busy=%b, required gnt=0001 busy=1", gnt, busy);
        end
    endtask

    task automatic test_single();
        logic [31:0] wd;
        int gnt_n = 0, vld_n = 0;
        drain();
        wd = $urandom;
        wd[23:16] = 8'hA5;
        for (int c = 1; c <= 14; c++) begin
            cycle(4'b0100, wd);
            checks++;
            if ({gnt, owner, q, q_vld, busy} !== {m_gnt, m_owner, m_q, m_qv, m_busy}) begin
                errors++;
                $display("FAIL single c%0d: got gnt=%b own=%0d q=%h vld=%b busy=%b, required gnt=%b own=%0d q=%h vld=%b busy=%b",
                         c, gnt, owner, q, q_vld, busy, m_gnt, m_owner, m_q, m_qv, m_busy);
            end
            if (c <= 7 && gnt === 4'b0100) gnt_n++;
            if (c <= 7 && q_vld === 1'b1) begin
                vld_n++;
                checks++;
                if (q !== 8'hA5 || owner !== 2'd2) begin
                    errors++;
                    $display("FAIL single_q: got q=%h owner=%0d, required q=a5 owner=2", q, owner);
                end
            end
            if (c == 8) begin
                checks++;
                if (gnt !== 4'b0100) begin
                    errors++;
                    $display("FAIL single_regrant: got gnt=%b at cycle 8, required 0100", gnt);
                end
            end
        end
        checks++;
        if (gnt_n != 5 || vld_n != 4) begin
            errors++;
            $display("FAIL single_len: got gnt cycles=%0d vld cycles=%0d, required 5 and 4", gnt_n, vld_n);
        end
    endtask

    task automatic test_rr();
        int got[$];
        logic [3:0] prev;
        int s;
        drain();
        s = int'(m_ptr);
        prev = gnt;
        for (int c = 0; c < 36; c++) begin
            cycle(4'hF, $urandom);
            checks++;
            if ({gnt, owner, q, q_vld, busy} !== {m_gnt, m_owner, m_q, m_qv, m_busy}) begin
                errors++;
                $display("FAIL rr c%0d: got gnt=%b own=%0d q=%h vld=%b busy=%b, required gnt=%b own=%0d q=%h vld=%b busy=%b",
                         c, gnt, owner, q, q_vld, busy, m_gnt, m_owner, m_q, m_qv, m_busy);
            end
            if (prev == 4'b0 && gnt != 4'b0) got.push_back(int'(owner));
            prev = gnt;
        end
        checks++;
        if (got.size() < 5) begin
            errors++;
            $display("FAIL rr_count: got %0d grants, required 5", got.size());
        end
        for (int k = 0; k < 5 && k < got.size(); k++) begin
            int exp;
`ifdef FIXED_PRIO_EN
            exp = 0;
`else
            exp = (s + k) % 4;
`endif
            checks++;
            if (got[k] != exp) begin
                errors++;
                $display("FAIL rr_order grant%0d: got owner=%0d, required %0d", k, got[k], exp);
            end
        end
    endtask

    task automatic test_early_drop();
        logic [31:0] wd;
        drain();
        wd = $urandom;
        repeat (3) cycle(4'b0010, wd);
        cycle(4'b0000, $urandom);
        checks++;
        if (gnt !== 4'b0 || q_vld !== 1'b0 || q !== wd[15:8] || busy !== 1'b1) begin
            errors++;
            $display("FAIL early_drop: got gnt=%b vld=%b q=%h busy=%b, required gnt=0000 vld=0 q=%h busy=1",
                     gnt, q_vld, q, busy, wd[15:8]);
        end
        cycle(4'b0000, $urandom);
        checks++;
        if ({gnt, owner, q, q_vld, busy} !== {m_gnt, m_owner, m_q, m_qv, m_busy} || q !== wd[15:8]) begin
            errors++;
            $display("FAIL early_hold: got gnt=%b own=%0d q=%h busy=%b, required q=%h own=1 busy=0",
                     gnt, owner, q, busy, wd[15:8]);
        end
    endtask

    task automatic test_async_reset();
        drain();
        repeat (3) cycle(4'hF, $urandom);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, owner, q, q_vld, busy} !== 16'h0) begin
            errors++;
            $display("FAIL async_reset: got gnt=%b owner=%0d q=%h vld=%b busy=%b, required all zero",
                     gnt, owner, q, q_vld, busy);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'hF;
        @(posedge clk);
        model_step(4'hF, wdata);
        #1;
        checks++;
        if (gnt !== 4'b0001 || owner !== 2'd0) begin
            errors++;
            $display("FAIL async_restart: got gnt=%b owner=%0d, required gnt=0001 owner=0", gnt, owner);
        end
    endtask

    task automatic test_wrap();
        int n = 0;
        drain();
        while (!m_rel && n < 12) begin
            cycle(4'b1000, $urandom);
            n++;
        end
        checks++;
        if (owner !== 2'd3 || gnt !== 4'b0) begin
            errors++;
            $display("FAIL wrap_owner: got owner=%0d gnt=%b, required owner=3 gnt=0000", owner, gnt);
        end
        cycle(4'b1001, $urandom);
        cycle(4'b1001, $urandom);
        checks++;
        if (gnt !== 4'b0001 || owner !== 2'd0) begin
            errors++;
            $display("FAIL wrap_grant: got gnt=%b owner=%0d, required gnt=0001 owner=0", gnt, owner);
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        r = 4'($urandom);
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(3) == 0) r = 4'($urandom);
            cycle(r, $urandom);
            checks++;
            if ({gnt, owner, q, q_vld, busy} !== {m_gnt, m_owner, m_q, m_qv, m_busy}) begin
                errors++;
                $display("FAIL random c%0d: got gnt=%b own=%0d q=%h vld=%b busy=%b, required gnt=%b own=%0d q=%h vld=%b busy=%b",
                         c, gnt, owner, q, q_vld, busy, m_gnt, m_owner, m_q, m_qv, m_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_early_drop();
        test_async_reset();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
